// File: rtl/alu_multicycle_exec.sv
// Execute-stage ALU: single-cycle logic/add/sub/slt/lui plus iterative arithmetic
// right shift and unsigned multiply behind a start/busy/done handshake.
module alu_multicycle_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic             src2_sel_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o
);

  localparam int MSB  = WIDTH - 1;
  localparam int HALF = WIDTH / 2;
  localparam int CW   = SHW + 1;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;
  localparam logic [3:0] OP_MULU = 4'd11;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [WIDTH-1:0]        acc;
  logic [WIDTH-1:0]        mcand;
  logic [WIDTH-1:0]        mplier;
  logic [WIDTH-1:0]        prod;
  logic [WIDTH-1:0]        prod_next;
  logic [SHW-1:0]          amt;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [WIDTH-1:0]        sum;
  logic [WIDTH-1:0]        diff;
  logic [WIDTH-1:0]        single_res;
  logic                    single_ovf;
  logic                    launch_shift;
  logic                    launch_mul;

  function automatic logic add_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] s);
    return (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] d);
    return (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]);
  endfunction

  function automatic logic [WIDTH-1:0] sra1(input logic [WIDTH-1:0] v);
    return {v[MSB], v[MSB:1]};
  endfunction

  assign amt          = src2_sel_i ? shamt_i : src1_i[SHW-1:0];
  assign a_s          = src1_i;
  assign b_s          = src2_i;
  assign sum          = src1_i + src2_i;
  assign diff         = src1_i - src2_i;
  assign launch_shift = (ctrl_i == OP_SRA) && (amt != '0);
  assign launch_mul   = (ctrl_i == OP_MULU);
  assign prod_next    = prod + (mplier[0] ? mcand : '0);
  assign zero_o       = (result_o == '0);

  // Single-cycle result; SRA by zero passes B straight through.
  always_comb begin
    single_res = '0;
    single_ovf = 1'b0;
    case (ctrl_i)
      OP_AND: single_res = src1_i & src2_i;
      OP_OR:  single_res = src1_i | src2_i;
      OP_ADD: begin
        single_res = sum;
        single_ovf = add_ovf(src1_i, src2_i, sum);
      end
      OP_SUB: begin
        single_res = diff;
        single_ovf = sub_ovf(src1_i, src2_i, diff);
      end
      OP_SLT: single_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SRA: single_res = src2_i;
      OP_LUI: single_res = {src2_i[HALF-1:0], {HALF{1'b0}}};
      default: single_res = '0;
    endcase
  end

  // Control, handshake and result registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      overflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (launch_shift) begin
              cnt    <= {1'b0, amt};
              busy_o <= 1'b1;
              state  <= ST_SHIFT;
            end else if (launch_mul) begin
              cnt    <= CW'(WIDTH);
              busy_o <= 1'b1;
              state  <= ST_MUL;
            end else begin
              result_o   <= single_res;
              overflow_o <= single_ovf;
              done_o     <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result_o   <= sra1(acc);
            overflow_o <= 1'b0;
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_MUL: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result_o   <= prod_next;
            overflow_o <= 1'b0;
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Iteration datapath: operands are captured at acceptance and never reset
  always_ff @(posedge clk_i) begin
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          acc    <= src2_i;
          mcand  <= src1_i;
          mplier <= src2_i;
          prod   <= '0;
        end
      end
      ST_SHIFT: acc <= sra1(acc);
      ST_MUL: begin
        prod   <= prod_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_multicycle_exec.sv
// Randomised and directed bench for alu_multicycle_exec against a plain-arithmetic model.
module tb_alu_multicycle_exec;

  localparam int W  = 32;
  localparam int SW = 5;
  localparam longint SMAX = (64'sd1 <<< 31) - 64'sd1;
  localparam longint SMIN = -(64'sd1 <<< 31);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    ctrl = 4'd0;
  logic          sel = 1'b0;
  logic [W-1:0]  src1 = '0;
  logic [W-1:0]  src2 = '0;
  logic [SW-1:0] shamt = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          zero;
  logic          ovf;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_multicycle_exec #(.WIDTH(W), .SHW(SW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl), .src2_sel_i(sel),
    .src1_i(src1), .src2_i(src2), .shamt_i(shamt), .busy_o(busy), .done_o(done),
    .result_o(result), .zero_o(zero), .overflow_o(ovf)
  );

  // Reference: result, overflow and cycles from acceptance to done.
  function automatic void model(input logic [3:0] c, input logic s, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [SW-1:0] sh,
                                output logic [W-1:0] r, output logic o, output int lat);
    longint sa, sb, t;
    logic signed [W-1:0] bs;
    logic [63:0] p;
    int amount;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    bs = b;
    amount = s ? int'(sh) : int'(a[SW-1:0]);
    r = '0; o = 1'b0; lat = 0;
    case (c)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin t = sa + sb; r = t[W-1:0]; o = (t > SMAX) || (t < SMIN); end
      4'd6: begin t = sa - sb; r = t[W-1:0]; o = (t > SMAX) || (t < SMIN); end
      4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: begin r = bs >>> amount; lat = amount; end
      4'd10: r = {b[15:0], 16'h0000};
      4'd11: begin p = {32'h0, a} * {32'h0, b}; r = p[W-1:0]; lat = W; end
      default: r = '0;
    endcase
  endfunction

  // Launches one op and follows it to done; inputs are scrambled right after acceptance.
  task automatic run_op(input logic [3:0] c, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [SW-1:0] sh,
                        output int cyc, output int busy_n, output bit stable, output bit tmo);
    logic [W-1:0] prev;
    prev = result;
    ctrl = c; sel = s; src1 = a; src2 = b; shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src1 = $urandom; src2 = $urandom; shamt = SW'($urandom); sel = 1'($urandom);
    ctrl = 4'($urandom);
    cyc = 0; busy_n = 0; stable = 1'b1; tmo = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_n++;
      if (result !== prev) stable = 1'b0;
      if (cyc >= 100) begin tmo = 1'b1; break; end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (result !== '0) begin fails++; $display("FAIL reset_result got=%h want=0", result); end
    checks++; if (zero !== 1'b1) begin fails++; $display("FAIL reset_zero got=%b want=1", zero); end
    checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    rst = 1'b1;
  endtask

  task automatic test_single;
    logic [3:0]   tc[9] = '{4'd2, 4'd6, 4'd7, 4'd10, 4'd0, 4'd15, 4'd1, 4'd6, 4'd9};
    logic [W-1:0] ta[9] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h0, 32'hF0F0, 32'hFFFFFFFF,
                            32'h0F, 32'h80000000, 32'h0};
    logic [W-1:0] tb[9] = '{32'd1, 32'd5, 32'd1, 32'h00001234, 32'hFF00, 32'hFFFFFFFF,
                            32'hF0, 32'd1, 32'h80000000};
    logic [W-1:0] tr[9] = '{32'h80000000, 32'h0, 32'h1, 32'h12340000, 32'hF000, 32'h0,
                            32'hFF, 32'h7FFFFFFF, 32'h80000000};
    logic         to[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int cyc, bn; bit st, tmo;
    for (int i = 0; i < 9; i++) begin
      run_op(tc[i], 1'b0, ta[i], tb[i], 5'd7, cyc, bn, st, tmo);
      checks++; if (tmo || cyc != 0 || bn != 0) begin
        fails++; $display("FAIL single_lat[%0d] got cyc=%0d busy=%0d want cyc=0 busy=0", i, cyc, bn); end
      checks++; if (result !== tr[i]) begin
        fails++; $display("FAIL single_res[%0d] got=%h want=%h", i, result, tr[i]); end
      checks++; if (ovf !== to[i]) begin
        fails++; $display("FAIL single_ovf[%0d] got=%b want=%b", i, ovf, to[i]); end
      checks++; if (zero !== (tr[i] == '0)) begin
        fails++; $display("FAIL single_zero[%0d] got=%b want=%b", i, zero, tr[i] == '0); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin
        fails++; $display("FAIL single_pulse[%0d] got=%b want=0", i, done); end
    end
  endtask

  task automatic test_sra;
    int cyc, bn; bit st, tmo;
    run_op(4'd9, 1'b1, 32'h0, 32'h80000000, 5'd4, cyc, bn, st, tmo);
    checks++; if (tmo || cyc != 4) begin fails++; $display("FAIL sra4_lat got=%0d want=4", cyc); end
    checks++; if (bn != 4) begin fails++; $display("FAIL sra4_busy got=%0d want=4", bn); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL sra4_busy_fall got=%b want=0", busy); end
    checks++; if (!st) begin fails++; $display("FAIL sra4_hold got=changed want=held"); end
    checks++; if (result !== 32'hF8000000) begin
      fails++; $display("FAIL sra4_res got=%h want=f8000000", result); end
    // start in the done cycle must be accepted
    run_op(4'd2, 1'b0, 32'd2, 32'd3, 5'd0, cyc, bn, st, tmo);
    checks++; if (tmo || cyc != 0 || result !== 32'd5) begin
      fails++; $display("FAIL sra_done_start got cyc=%0d res=%h want cyc=0 res=5", cyc, result); end
    run_op(4'd9, 1'b1, 32'h0, 32'h80000000, 5'd31, cyc, bn, st, tmo);
    checks++; if (tmo || cyc != 31 || result !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL sra31 got cyc=%0d res=%h want cyc=31 res=ffffffff", cyc, result); end
  endtask

  task automatic test_mulu_ignore;
    int cyc; bit extra;
    ctrl = 4'd11; src1 = 32'h00010003; src2 = 32'h5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc == 9) begin start = 1'b1; ctrl = 4'd11; src1 = 32'hDEADBEEF; src2 = 32'h77; end
      else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checks++; if (cyc != 32) begin fails++; $display("FAIL mulu_lat got=%0d want=32", cyc); end
    checks++; if (result !== 32'h0005000F) begin
      fails++; $display("FAIL mulu_res got=%h want=0005000f", result); end
    extra = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
    end
    checks++; if (extra) begin fails++; $display("FAIL mulu_no_queue got=activity want=idle"); end
    checks++; if (result !== 32'h0005000F) begin
      fails++; $display("FAIL mulu_hold got=%h want=0005000f", result); end
  endtask

  task automatic test_reset_abort;
    int cyc, bn; bit st, tmo, seen;
    ctrl = 4'd11; src1 = 32'h12345; src2 = 32'h777; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 15; i++) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL abort_ctrl got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (result !== '0 || zero !== 1'b1) begin
      fails++; $display("FAIL abort_res got=%h zero=%b want=0 zero=1", result, zero); end
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin fails++; $display("FAIL abort_no_done got=done want=none"); end
    run_op(4'd2, 1'b0, 32'd2, 32'd3, 5'd0, cyc, bn, st, tmo);
    checks++; if (tmo || cyc != 0 || result !== 32'd5) begin
      fails++; $display("FAIL abort_add got cyc=%0d res=%h want cyc=0 res=5", cyc, result); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops[7] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd10, 4'd13};
    logic [W-1:0] er; logic eo; int lat;
    logic [3:0] c; logic [W-1:0] a, b;
    for (int i = 0; i < 16; i++) begin
      c = ops[$urandom_range(0, 6)]; a = $urandom; b = $urandom;
      model(c, 1'b0, a, b, 5'd0, er, eo, lat);
      ctrl = c; src1 = a; src2 = b; sel = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      checks++; if (done !== 1'b1 || result !== er || ovf !== eo) begin
        fails++; $display("FAIL b2b[%0d] op=%0d got done=%b res=%h ovf=%b want done=1 res=%h ovf=%b",
                          i, c, done, result, ovf, er, eo); end
    end
    start = 1'b0;
  endtask

  task automatic test_random;
    logic [3:0] ops[11] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd3, 4'd12, 4'd15};
    logic [W-1:0] er; logic eo; int lat;
    logic [3:0] c; logic s; logic [W-1:0] a, b; logic [SW-1:0] sh;
    int cyc, bn; bit st, tmo;
    for (int i = 0; i < 40; i++) begin
      c = ops[$urandom_range(0, 10)]; s = 1'($urandom);
      a = $urandom; b = $urandom; sh = SW'($urandom);
      if ($urandom_range(0, 3) == 0) b = {b[W-1], {(W-1){b[W-1]}}} ^ 32'h1;
      model(c, s, a, b, sh, er, eo, lat);
      run_op(c, s, a, b, sh, cyc, bn, st, tmo);
      checks++; if (tmo || cyc != lat) begin
        fails++; $display("FAIL rnd_lat[%0d] op=%0d got=%0d want=%0d", i, c, cyc, lat); end
      checks++; if (bn != lat || busy !== 1'b0) begin
        fails++; $display("FAIL rnd_busy[%0d] op=%0d got=%0d/%b want=%0d/0", i, c, bn, busy, lat); end
      checks++; if (!st) begin fails++; $display("FAIL rnd_hold[%0d] got=changed want=held", i); end
      checks++; if (result !== er) begin
        fails++; $display("FAIL rnd_res[%0d] op=%0d a=%h b=%h got=%h want=%h", i, c, a, b, result, er); end
      checks++; if (ovf !== eo || zero !== (er == '0)) begin
        fails++; $display("FAIL rnd_flags[%0d] got ovf=%b zero=%b want ovf=%b zero=%b",
                          i, ovf, zero, eo, er == '0); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_sra;
    test_mulu_ignore;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_multicycle_exec.md
# alu_multicycle_exec

Execute-stage datapath unit that consumes the 4-bit operation code and shift-source select produced by the ALU control block and computes the result over one or more clock cycles. Logic ops, add/sub and slt finish in one cycle. Arithmetic right shift and unsigned multiply run iteratively behind a start/busy/done handshake, so the CPU control stalls while `busy_o` is high. The unit sits between the register file/immediate mux (operands) and the write-back mux (result).

## Interface
- `WIDTH`, 32: operand and result width; an even number of at least 8.
- `SHW`, 5: shift-amount width; 2^SHW == WIDTH.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset. Synchronous, active-low: sampled on the `clk_i` rising edge, active when 0.
- `start_i`  in  1  launch an operation; accepted only when `busy_o`=0.
- `ctrl_i`  in  4  operation code from ALU control.
- `src2_sel_i`  in  1  shift-amount select, from ALU control: 1 = `shamt_i`, 0 = `src1_i[SHW-1:0]`.
- `src1_i`  in  WIDTH  operand A (rs).
- `src2_i`  in  WIDTH  operand B (rt or immediate).
- `shamt_i`  in  SHW  instruction shift-amount field.
- `busy_o`  out  1  operation in progress.
- `done_o`  out  1  one-cycle pulse; the result is valid from this cycle.
- `result_o`  out  WIDTH  registered result; held until the next completion.
- `zero_o`  out  1  `result_o`==0; combinational from the `result_o` register.
- `overflow_o`  out  1  signed overflow of the last ADD/SUB, else 0; registered with `result_o`.

## Operation
- Codes:
  - 0 AND; 1 OR; 2 ADD; 6 SUB (A−B).
  - 7 SLT: signed A<B gives 1, else 0.
  - 9 SRA: B arithmetic right-shifted by the selected amount.
  - 10 LUI: B[15:0] placed in the upper half, zeros below.
  - 11 MULU: low WIDTH bits of A×B, unsigned.
  - Any other code: result 0, `overflow_o` 0, single-cycle timing.
- The operands, code, select and amount are captured into internal registers at acceptance. Input changes after acceptance have no effect.
- State machine IDLE / SHIFT / MUL:
  - IDLE, with `start_i`=1 and a single-cycle code: compute, load the result, pulse `done_o` next cycle, stay in IDLE.
  - IDLE, with `start_i`=1 and code 9: load acc=B and cnt=amount.
    - If amount is 0: finish as a single-cycle op.
    - Otherwise go to SHIFT and set `busy_o`.
  - SHIFT: each cycle acc = {acc[MSB], acc[WIDTH-1:1]} and cnt−1. When cnt reaches 1, write the shifted value to `result_o`, pulse `done_o`, return to IDLE.
  - IDLE, with `start_i`=1 and code 11: load multiplicand=A, multiplier=B, product=0, cnt=WIDTH; go to MUL and set `busy_o`.
  - MUL: each cycle, if multiplier[0] is 1, product += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; cnt−1. The final iteration writes `result_o`, pulses `done_o`, returns to IDLE.
- ADD/SUB overflow: set when the operands' signs make the true result unrepresentable. ADD: same-sign operands with a different-sign result. SUB: different-sign operands where the result's sign differs from A's. The result wraps mod 2^WIDTH.
- `start_i` while `busy_o`=1 is ignored and does not queue.
- `start_i` in the same cycle as `done_o` (unit back in IDLE) is accepted.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `result_o`=0, `overflow_o`=0, `zero_o`=1, state IDLE, counters 0.
- Reset asserted mid-operation aborts it: no `done_o`, `result_o` goes to 0 on that edge.
- Latency is measured from the edge that accepts `start_i`:
  - single-cycle ops, SRA by 0, and unknown codes: `done_o` in the next cycle, `busy_o` never asserted;
  - SRA by n≥1: `busy_o` high for n cycles, `done_o` n cycles after acceptance, coincident with `busy_o` falling;
  - MULU: `busy_o` high for WIDTH cycles, `done_o` WIDTH cycles after acceptance.
- Throughput: back-to-back single-cycle ops, one per clock.
- `result_o`, `zero_o` and `overflow_o` change only on a `done_o` cycle or on reset.

## Test plan
- Reset: hold `rst_i`=0 for 2 cycles -> `busy_o`=0, `done_o`=0, `result_o`=0, `zero_o`=1.
- ADD 0x7FFFFFFF+1 -> next cycle `result_o`=0x80000000, `overflow_o`=1, `done_o` pulses once. Then SUB 5−5 -> `result_o`=0, `zero_o`=1, `overflow_o`=0.
- SLT A=0xFFFFFFFF, B=1 -> 1. LUI B=0x00001234 -> 0x12340000. AND 0xF0F0,0xFF00 -> 0xF000. ctrl 4'd15 -> 0.
- SRA B=0x80000000:
  - `src2_sel_i`=1, `shamt_i`=4 -> `busy_o` high 4 cycles, then `result_o`=0xF8000000;
  - `src2_sel_i`=0, A=0 -> done next cycle, `result_o`=0x80000000.
- MULU 0x0001_0003×0x0000_0005 -> `done_o` at cycle 32, `result_o`=0x0005000F. Re-issue `start_i` at cycle 10 with different operands -> ignored, same result.
- Issue MULU and drive `rst_i`=0 at cycle 15 -> `busy_o`=0 next edge, no `done_o`, `result_o`=0. A subsequent ADD 2+3 -> 5 in one cycle.
